// File: rtl/keypad_scan_fifo_pkg.sv
// Shared definitions for the keypad front end: scanner states and the
// direct-button key codes consumed by the calculator core.
package keypad_scan_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_FRAME,
        ST_EMIT
    } scan_state_t;

    // Direct-button codes for the default 4x4 matrix (offset = N_ROWS*N_COLS).
    localparam int unsigned KEY_DIRECT_BASE = 16;
    localparam int unsigned KEY_AC  = KEY_DIRECT_BASE + 0;
    localparam int unsigned KEY_ADD = KEY_DIRECT_BASE + 1;
    localparam int unsigned KEY_SUB = KEY_DIRECT_BASE + 2;
    localparam int unsigned KEY_MUL = KEY_DIRECT_BASE + 3;
    localparam int unsigned KEY_DIV = KEY_DIRECT_BASE + 4;
    localparam int unsigned KEY_EQ  = KEY_DIRECT_BASE + 5;

endpackage

// File: rtl/keypad_scan_fifo_fifo.sv
// Key-event FIFO: first-word fall-through head, occupancy level, full flag.
module key_event_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner with frame debounce; new presses become key codes
// queued in a FIFO and presented on a valid/ready port.
module keypad_scan_fifo
    import keypad_scan_fifo_pkg::*;
#(
    parameter int unsigned N_ROWS         = 4,
    parameter int unsigned N_COLS         = 4,
    parameter int unsigned N_DIRECT       = 6,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned NKEYS         = N_ROWS * N_COLS + N_DIRECT,
    localparam int unsigned CODE_W        = $clog2(NKEYS),
    localparam int unsigned LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_scan_en,
    output logic [N_ROWS-1:0]   o_word_lines,
    input  logic [N_COLS-1:0]   i_bit_lines,
    input  logic [N_DIRECT-1:0] i_direct,
    output logic [CODE_W-1:0]   o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_overflow,
    input  logic                i_clr_overflow,
    output logic [LVL_W-1:0]    o_level
);
    localparam int unsigned NMAT  = N_ROWS * N_COLS;
    localparam int unsigned ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(N_ROWS - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DB_MAX      = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CODE_W-1:0] LAST_IDX    = CODE_W'(NKEYS - 1);

    scan_state_t         state, state_next;
    logic [N_COLS-1:0]   bl_s1, bl_s2;
    logic [N_DIRECT-1:0] di_s1, di_s2;
    logic [ROW_W-1:0]    row;
    logic [SET_W-1:0]    settle;
    logic [NMAT-1:0]     frame_mat;
    logic [NKEYS-1:0]    frame_full, cand, stable, mask, new_mask;
    logic [CNT_W-1:0]    count, cnt_inc;
    logic [CODE_W-1:0]   idx;
    logic                accept;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;

    assign frame_full = {di_s2, frame_mat};

    always_comb begin
        cnt_inc = CNT_W'(1);
        if (frame_full == cand) begin
            cnt_inc = (count == DB_MAX) ? count : count + 1'b1;
        end
        accept   = (cnt_inc == DB_MAX);
        new_mask = accept ? (frame_full & ~stable) : '0;
    end

    always_comb begin
        state_next   = state;
        o_word_lines = '0;
        push         = 1'b0;
        case (state)
            ST_IDLE:   state_next = ST_DRIVE;
            ST_DRIVE: begin
                o_word_lines = N_ROWS'(1) << row;
                if (settle == LAST_SETTLE) state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                o_word_lines = N_ROWS'(1) << row;
                state_next   = (row == LAST_ROW) ? ST_FRAME : ST_DRIVE;
            end
            ST_FRAME:  state_next = (|new_mask) ? ST_EMIT : ST_DRIVE;
            ST_EMIT: begin
                push = mask[idx];
                if (idx == LAST_IDX) state_next = ST_DRIVE;
            end
            default:   state_next = ST_IDLE;
        endcase
        if (!i_scan_en) begin
            state_next = ST_IDLE;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bl_s1     <= '0;
            bl_s2     <= '0;
            di_s1     <= '0;
            di_s2     <= '0;
            row       <= '0;
            settle    <= '0;
            frame_mat <= '0;
            cand      <= '0;
            stable    <= '0;
            mask      <= '0;
            count     <= '0;
            idx       <= '0;
        end else begin
            state <= state_next;
            bl_s1 <= i_bit_lines;
            bl_s2 <= bl_s1;
            di_s1 <= i_direct;
            di_s2 <= di_s1;
            // Disabling keeps candidate/stable so held keys do not re-fire.
            if (!i_scan_en) begin
                row    <= '0;
                settle <= '0;
                idx    <= '0;
            end else begin
                case (state)
                    ST_DRIVE: settle <= (settle == LAST_SETTLE) ? '0 : settle + 1'b1;
                    ST_SAMPLE: begin
                        for (int unsigned r = 0; r < N_ROWS; r++) begin
                            if (row == ROW_W'(r)) frame_mat[r*N_COLS +: N_COLS] <= bl_s2;
                        end
                        row    <= (row == LAST_ROW) ? '0 : row + 1'b1;
                        settle <= '0;
                    end
                    ST_FRAME: begin
                        cand  <= frame_full;
                        count <= cnt_inc;
                        if (accept) begin
                            stable <= frame_full;
                            mask   <= new_mask;
                        end
                        idx    <= '0;
                        row    <= '0;
                        settle <= '0;
                    end
                    ST_EMIT: idx <= idx + 1'b1;
                    default: begin
                        row    <= '0;
                        settle <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
        end else if (push && fifo_full && !i_ready) begin
            o_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
        end
    end

    assign o_valid = !fifo_empty;

    key_event_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (idx),
        .pop       (i_ready),
        .head      (o_data),
        .level     (o_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a modelled 4x4 key matrix plus direct
// buttons, checked with immediate assertions against hand-derived values.
module tb_keypad_scan_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic [3:0] wl;
    logic [3:0] bl;
    logic [5:0] direct;
    logic [4:0] data;
    logic       valid;
    logic       ready;
    logic       ovf;
    logic       clr;
    logic [2:0] level;
    logic [15:0] keys;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    // Physical matrix: a closed key connects its word line to its bit line.
    always_comb begin
        bl = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (wl[r] && keys[r*4+c]) bl[c] = 1'b1;
    end

    keypad_scan_fifo #(
        .N_ROWS         (4),
        .N_COLS         (4),
        .N_DIRECT       (6),
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_scan_en      (scan_en),
        .o_word_lines   (wl),
        .i_bit_lines    (bl),
        .i_direct       (direct),
        .o_data         (data),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_overflow     (ovf),
        .i_clr_overflow (clr),
        .o_level        (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int cnt);
        cnt = 0;
        while (valid !== 1'b1 && cnt < maxc) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(tag, {31'd0, valid}, 32'd1);
    endtask

    task automatic pop_one();
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        scan_en = 1'b1;
        ready   = 1'b0;
        clr     = 1'b0;
        direct  = '0;
        keys    = '0;

        // 1. reset state and first row drive
        idle(3);
        chk("rst_wl",    {28'd0, wl}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf}, 32'd0);
        chk("rst_data",  {27'd0, data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        chk("row0_rise", {28'd0, wl}, 32'd1);
        idle(80);

        // 2. key row2/col1 held: one code 9, held at head while not ready
        keys[9] = 1'b1;
        wait_valid("k9_timeout", 200, cyc);
        chk("k9_latency_ok", {31'd0, (cyc >= 40 && cyc <= 120)}, 32'd1);
        chk("k9_data", {27'd0, data}, 32'd9);
        idle(30);
        chk("k9_held", {27'd0, data}, 32'd9);
        idle(60);
        chk("k9_once", {29'd0, level}, 32'd1);
        pop_one();
        chk("k9_pop_level", {29'd0, level}, 32'd0);
        chk("k9_pop_valid", {31'd0, valid}, 32'd0);
        chk("k9_pop_data",  {27'd0, data}, 32'd0);
        keys[9] = 1'b0;
        idle(100);

        // 3. bounce on key 2, then clean press, release, re-press
        keys[2] = 1'b1;
        idle(21);
        keys[2] = 1'b0;
        idle(63);
        chk("bounce_none", {29'd0, level}, 32'd0);
        keys[2] = 1'b1;
        wait_valid("k2_timeout", 200, cyc);
        chk("k2_data", {27'd0, data}, 32'd2);
        pop_one();
        keys[2] = 1'b0;
        idle(120);
        chk("release_none", {29'd0, level}, 32'd0);
        keys[2] = 1'b1;
        wait_valid("k2b_timeout", 200, cyc);
        chk("k2b_data", {27'd0, data}, 32'd2);
        pop_one();
        chk("k2b_level", {29'd0, level}, 32'd0);
        keys[2] = 1'b0;
        idle(100);

        // 4. key 5 and '=' in the same frame
        keys[5]   = 1'b1;
        direct[5] = 1'b1;
        wait_valid("pair_timeout", 200, cyc);
        chk("pair_first", {27'd0, data}, 32'd5);
        idle(20);
        chk("pair_level", {29'd0, level}, 32'd2);
        pop_one();
        chk("pair_second", {27'd0, data}, 32'd21);
        pop_one();
        chk("pair_empty", {29'd0, level}, 32'd0);
        keys[5]   = 1'b0;
        direct[5] = 1'b0;
        idle(100);

        // 5. five presses into a depth-4 FIFO
        keys[0] = 1'b1; keys[3] = 1'b1; keys[6] = 1'b1;
        direct[0] = 1'b1; direct[4] = 1'b1;
        wait_valid("ovf_timeout", 200, cyc);
        idle(30);
        chk("ovf_level", {29'd0, level}, 32'd4);
        chk("ovf_flag",  {31'd0, ovf}, 32'd1);
        chk("ovf_q0", {27'd0, data}, 32'd0);
        pop_one();
        chk("ovf_q1", {27'd0, data}, 32'd3);
        pop_one();
        chk("ovf_q2", {27'd0, data}, 32'd6);
        pop_one();
        chk("ovf_q3", {27'd0, data}, 32'd16);
        pop_one();
        chk("ovf_drained", {29'd0, level}, 32'd0);
        chk("ovf_sticky",  {31'd0, ovf}, 32'd1);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        chk("ovf_clear", {31'd0, ovf}, 32'd0);
        keys = '0;
        direct = '0;
        idle(100);

        // 6. scan disabled mid-DRIVE with key held
        keys[9] = 1'b1;
        wait_valid("k9c_timeout", 200, cyc);
        pop_one();
        idle(1);
        cyc = 0;
        while (wl === 4'd0 && cyc < 30) begin
            idle(1);
            cyc++;
        end
        chk("drive_seen", {31'd0, (wl !== 4'd0)}, 32'd1);
        scan_en = 1'b0;
        idle(1);
        chk("off_wl",    {28'd0, wl}, 32'd0);
        idle(9);
        chk("off_wl_10", {28'd0, wl}, 32'd0);
        scan_en = 1'b1;
        idle(2);
        chk("resume_row0", {28'd0, wl}, 32'd1);
        idle(150);
        chk("no_dup_level", {29'd0, level}, 32'd0);
        chk("no_dup_valid", {31'd0, valid}, 32'd0);
        keys = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
